// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer: FSM state encoding,
// datapath widths and the saturating fold of a MAC result into the accumulator.
package mac_seq_pkg;

  localparam int A_W         = 4;
  localparam int B_W         = 4;
  localparam int C_W         = 8;
  localparam int R_W         = C_W + 1;
  localparam int LEN_W       = 4;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [C_W-1:0] SAT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [C_W-1:0] val;
    logic           sat;
  } fold_t;

  // Clamp a MAC result to the accumulator range, flagging when it clipped.
  function automatic fold_t sat_fold(input logic [R_W-1:0] r);
    fold_t f;
    f.sat = (r > {1'b0, SAT_MAX});
    f.val = f.sat ? SAT_MAX : r[C_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/mac_seq_watchdog.sv
// Cycle counter guarding the ISSUE wait: cleared when an operand pair is
// accepted, counts while enabled, and flags expiry on its last allowed cycle.
module mac_seq_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: takes a (length, bias) job, feeds operand pairs to an
// external MAC with the running sum as addend, and returns the saturated total.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [C_W-1:0]   cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [A_W-1:0]   op_a,
  input  logic [B_W-1:0]   op_b,
  output logic             mac_reset,
  output logic [A_W-1:0]   mac_a,
  output logic [B_W-1:0]   mac_b,
  output logic [C_W-1:0]   mac_c,
  input  logic [R_W-1:0]   mac_result,
  input  logic             mac_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [C_W-1:0]   res_data,
  output logic             res_sat,
  output logic             res_err
);

  state_e           state_q, state_d;
  logic [C_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic             first_q, first_d;
  logic [A_W-1:0]   mac_a_q, mac_a_d;
  logic [B_W-1:0]   mac_b_q, mac_b_d;
  logic [C_W-1:0]   mac_c_q, mac_c_d;

  logic  fetch_accept;
  logic  issue_done;
  logic  wdog_expire;
  fold_t fold;

  assign fetch_accept = (state_q == FETCH) && op_valid;
  // The MAC is being cleared on the first ISSUE cycle, so its done is stale then.
  assign issue_done   = (state_q == ISSUE) && !first_q && mac_done;
  assign fold         = sat_fold(mac_result);

  mac_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (fetch_accept),
    .en_i     (state_q == ISSUE),
    .expire_o (wdog_expire)
  );

  // NOTE: every next-state signal gets a hold default before the case, so no
  // path through the block leaves a variable unassigned and no latch appears.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    err_d   = err_q;
    first_d = first_q;
    mac_a_d = mac_a_q;
    mac_b_d = mac_b_q;
    mac_c_d = mac_c_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          acc_d   = cmd_bias;
          count_d = cmd_len;
          sat_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (cmd_len == '0) ? OUT : FETCH;
        end
      end
      FETCH: begin
        if (op_valid) begin
          mac_a_d = op_a;
          mac_b_d = op_b;
          mac_c_d = acc_q;
          first_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        first_d = 1'b0;
        if (issue_done) begin
          acc_d   = fold.val;
          sat_d   = sat_q | fold.sat;
          count_d = count_q - LEN_W'(1);
          state_d = (count_q == LEN_W'(1)) ? OUT : FETCH;
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so a job dropped by reset
  // leaves nothing behind on the MAC or result ports.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      mac_c_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      first_q <= first_d;
      mac_a_q <= mac_a_d;
      mac_b_q <= mac_b_d;
      mac_c_q <= mac_c_d;
    end
  end

  // Outputs are forced low while reset is asserted, even before the first edge.
  logic run;
  assign run = !reset;

  assign cmd_ready = run && (state_q == IDLE);
  assign op_ready  = run && (state_q == FETCH);
  assign mac_reset = run && (state_q == ISSUE) && first_q;
  assign mac_a     = run ? mac_a_q : '0;
  assign mac_b     = run ? mac_b_q : '0;
  assign mac_c     = run ? mac_c_q : '0;
  assign res_valid = run && (state_q == OUT);
  assign res_data  = res_valid ? acc_q : '0;
  assign res_sat   = res_valid && sat_q;
  assign res_err   = res_valid && err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed job table, a reset-abort
// sequence and randomized jobs scored against an arithmetic reference model.
module tb_mac_seq_ctrl;
  import mac_seq_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [C_W-1:0]   cmd_bias = '0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [A_W-1:0]   op_a = '0;
  logic [B_W-1:0]   op_b = '0;
  logic             mac_reset;
  logic [A_W-1:0]   mac_a;
  logic [B_W-1:0]   mac_b;
  logic [C_W-1:0]   mac_c;
  logic [R_W-1:0]   mac_result = '0;
  logic             mac_done = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [C_W-1:0]   res_data;
  logic             res_sat;
  logic             res_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  mac_seq_ctrl #(.TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_bias   (cmd_bias),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .mac_reset  (mac_reset),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_c      (mac_c),
    .mac_result (mac_result),
    .mac_done   (mac_done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_sat    (res_sat),
    .res_err    (res_err)
  );

  // Ideal MAC: result is always a*b+c; done rises cur_dly cycles after the clear.
  int mac_cyc = 0;
  int cur_dly = 1;
  always @(negedge clock) begin
    if (mac_reset) mac_cyc = 0;
    else           mac_cyc = mac_cyc + 1;
    mac_done   = (mac_cyc >= cur_dly);
    mac_result = R_W'(int'(mac_a) * int'(mac_b) + int'(mac_c));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int job_a   [15];
  int job_b   [15];
  int job_dly [15];

  // Runs one job; the reference model folds each pair with plain arithmetic.
  task automatic run_job(input int bias, input int len, input int hold,
                         output int r_data, output int r_sat, output int r_err,
                         output int last_lat);
    int m_acc, m_sat, m_err, n, r;
    m_acc = bias; m_sat = 0; m_err = 0; last_lat = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_len = LEN_W'(len); cmd_bias = C_W'(bias);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clock); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clock); @(negedge clock);
    cmd_valid = 1'b0;
    if (len == 0) begin
      check("len0_res_valid", res_valid, 1);
      check("len0_op_ready", op_ready, 0);
    end
    for (int i = 0; i < len && m_err == 0; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clock);
      cur_dly = job_dly[i];
      op_valid = 1'b1; op_a = A_W'(job_a[i]); op_b = B_W'(job_b[i]);
      n = 0;
      while (!op_ready && n < 50) begin @(negedge clock); n++; end
      check("op_ready_wait", op_ready, 1);
      @(posedge clock); @(negedge clock);
      op_valid = 1'b0;
      check("mac_a_issue", mac_a, job_a[i]);
      check("mac_b_issue", mac_b, job_b[i]);
      check("mac_c_issue", mac_c, m_acc);
      if (job_dly[i] + 1 > 16) begin
        m_err = 1;
      end else begin
        r = job_a[i] * job_b[i] + m_acc;
        if (r > 255) begin m_acc = 255; m_sat = 1; end
        else m_acc = r;
      end
      n = 1;
      while (!(op_ready || res_valid) && n < 100) begin @(negedge clock); n++; end
      last_lat = n;
      check("mac_a_held", mac_a, job_a[i]);
    end
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clock); n++; end
    check("res_valid_wait", res_valid, 1);
    r_data = int'(res_data); r_sat = int'(res_sat); r_err = int'(res_err);
    check("res_data_model", res_data, m_acc);
    check("res_sat_model", res_sat, m_sat);
    check("res_err_model", res_err, m_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, r_data);
      check("hold_sat", res_sat, r_sat);
      check("hold_err", res_err, r_err);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    res_ready = 1'b0;
    check("post_res_valid", res_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  typedef struct {
    int          bias;
    int          len;
    logic [15:0] a;      // pair i operand a in nibble i
    logic [15:0] b;
    int          dly;
    int          hold;
    int          exp_data;
    int          exp_sat;
    int          exp_err;
    int          exp_lat; // cycles from last pair accept to leaving ISSUE
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  initial begin
    int d, s, e, l, len;
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d, s, e, l, len, bias;
    tbl[0] = '{3,   2, 16'h0042, 16'h0053, 1,  0, 29,  0, 0, 3};
    tbl[1] = '{250, 1, 16'h000F, 16'h000F, 1,  0, 255, 1, 0, 3};
    tbl[2] = '{17,  0, 16'h0000, 16'h0000, 1,  0, 17,  0, 0, 0};
    tbl[3] = '{42,  1, 16'h0007, 16'h0007, 99, 0, 42,  0, 1, 17};
    tbl[4] = '{0,   1, 16'h0001, 16'h0002, 15, 0, 2,   0, 0, 17};
    tbl[5] = '{5,   1, 16'h0003, 16'h0004, 16, 0, 5,   0, 1, 17};
    tbl[6] = '{9,   1, 16'h0003, 16'h0003, 1,  5, 18,  0, 0, 3};
    tbl[7] = '{200, 3, 16'h010F, 16'h0105, 2,  0, 255, 1, 0, 4};

    repeat (2) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_mac_reset", mac_reset, 0);
    check("rst_mac_c", mac_c, 0);
    check("rst_res_data", res_data, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rel_cmd_ready", cmd_ready, 1);

    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < 4; i++) begin
        job_a[i]   = int'(tbl[k].a[4*i +: 4]);
        job_b[i]   = int'(tbl[k].b[4*i +: 4]);
        job_dly[i] = tbl[k].dly;
      end
      run_job(tbl[k].bias, tbl[k].len, tbl[k].hold, d, s, e, l);
      check($sformatf("vec%0d_data", k), d, tbl[k].exp_data);
      check($sformatf("vec%0d_sat", k), s, tbl[k].exp_sat);
      check($sformatf("vec%0d_err", k), e, tbl[k].exp_err);
      if (tbl[k].len > 0) check($sformatf("vec%0d_lat", k), l, tbl[k].exp_lat);
    end

    // Reset while the MAC is stalled in ISSUE drops the job.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_len = LEN_W'(1); cmd_bias = C_W'(7);
    @(posedge clock); @(negedge clock);
    cmd_valid = 1'b0;
    cur_dly = 99; op_valid = 1'b1; op_a = 4'd2; op_b = 4'd2;
    check("abort_op_ready", op_ready, 1);
    @(posedge clock); @(negedge clock);
    op_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_in_issue", mac_a, 2);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_op_ready0", op_ready, 0);
    check("abort_mac_reset", mac_reset, 0);
    check("abort_mac_a", mac_a, 0);
    check("abort_mac_c", mac_c, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_err", res_err, 0);
    reset = 1'b0;
    @(negedge clock);
    check("abort_rel_cmd_ready", cmd_ready, 1);
    check("abort_no_result", res_valid, 0);
    job_a[0] = 1; job_b[0] = 1; job_dly[0] = 1;
    run_job(1, 1, 0, d, s, e, l);
    check("after_abort_data", d, 2);
    check("after_abort_err", e, 0);

    for (int j = 0; j < 40; j++) begin
      len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
      bias = int'($urandom_range(0, 255));
      for (int i = 0; i < 15; i++) begin
        job_a[i]   = int'($urandom_range(0, 15));
        job_b[i]   = int'($urandom_range(0, 15));
        job_dly[i] = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18))
                                                  : int'($urandom_range(1, 4));
      end
      run_job(bias, len, int'($urandom_range(0, 2)), d, s, e, l);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
